// File: rtl/dma_ahb_pkg.sv
// AHB-lite constants and address-phase payload shared by the DMA AHB master and its slaves.
package dma_ahb_pkg;

  localparam int unsigned AHB_AW = 32;
  localparam int unsigned AHB_DW = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef struct packed {
    logic [AHB_AW-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
  } ahb_addr_phase_t;

endpackage

// File: rtl/dma_sram_1rw.sv
// Word-addressed SRAM: one synchronous write port, one combinational read port.
module dma_sram_1rw #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset; contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dma_ahb_sram_slave.sv
// AHB-lite SRAM slave for the DMA bus: programmable wait states, two-cycle ERROR on illegal beats.
module dma_ahb_sram_slave
  import dma_ahb_pkg::*;
#(
  parameter int unsigned AW          = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned CW      = 4;
  localparam int unsigned OW      = AHB_AW + 1;
  localparam logic [OW-1:0] WIN_LO = OW'(BASE_ADDR);
  localparam logic [CW-1:0] WS_LOAD =
    CW'((WAIT_STATES == 0) ? 0 : (WAIT_STATES - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e          r_state;
  logic [AW-1:0]   r_addr;
  logic            r_wr;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_hrdata;
  logic            r_hreadyout;
  logic            r_hresp;

  ahb_addr_phase_t w_ap;
  logic [OW-1:0]   w_off;
  logic [AW-1:0]   w_idx;
  logic            w_accept;
  logic            w_legal;
  logic            w_we;
  logic [AW-1:0]   w_raddr;
  logic [31:0]     w_mem_rdata;
  logic [31:0]     w_rd_fwd;
  logic            w_unused;

  assign w_ap = '{haddr: HADDR, htrans: HTRANS, hwrite: HWRITE, hsize: HSIZE};

  // Offset into the window; a borrow or any bit above the index means out of range.
  assign w_off    = {1'b0, w_ap.haddr} - WIN_LO;
  assign w_idx    = w_off[AW+1:2];
  assign w_accept = HSEL & w_ap.htrans[1] & HREADY;
  assign w_legal  = (w_ap.hsize == HSIZE_WORD) && (w_off[1:0] == 2'b00) &&
                    (w_off[OW-1:AW+2] == '0);

  assign w_unused = ^{w_ap.htrans[0], HBURST};

  // A write commits at the edge leaving S_DATA; a read launched on that edge sees HWDATA.
  assign w_we     = (r_state == S_DATA) && r_wr;
  assign w_raddr  = (r_state == S_WAIT) ? r_addr : w_idx;
  assign w_rd_fwd = (w_we && (r_addr == w_raddr)) ? HWDATA : w_mem_rdata;

  dma_sram_1rw #(
    .AW (AW),
    .DW (AHB_DW)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (HWDATA),
    .i_raddr (w_raddr),
    .o_rdata (w_mem_rdata)
  );

  // Slave FSM; all bus outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_cnt       <= '0;
      r_hrdata    <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
    end else begin
      r_hrdata <= '0;
      case (r_state)
        S_IDLE, S_DATA: begin
          if (w_accept) begin
            r_addr <= w_idx;
            r_wr   <= w_ap.hwrite;
            if (!w_legal) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_ERROR;
            end else if (WAIT_STATES != 0) begin
              r_state     <= S_WAIT;
              r_cnt       <= WS_LOAD;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_OKAY;
            end else begin
              r_state     <= S_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= HRESP_OKAY;
              if (!w_ap.hwrite) begin
                r_hrdata <= w_rd_fwd;
              end
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            if (!r_wr) begin
              r_hrdata <= w_rd_fwd;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end
        S_ERR2: begin
          r_state     <= S_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
        end
        default: begin
          r_state     <= S_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign HRDATA    = r_hrdata;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

endmodule
